// File: rtl/frame_sched_pkg.sv
`default_nettype none
// =============================================================================
// frame_sched_pkg : shared state type and constants for frame_write_scheduler
// Rev 1.0
// =============================================================================
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 400000;

  // cur must reach NUM_SOURCES itself, which marks the end of a pass.
  function automatic int cur_width(input int num_sources);
    return $clog2(num_sources + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sched_watchdog.sv
`default_nettype none
// =============================================================================
// sched_watchdog : clear/enable cycle timer, expired is high at TIMEOUT_CYCLES-1
// Rev 1.0
// =============================================================================
module sched_watchdog
  import frame_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic resetN,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             expired_q, expired_d;

  // The count parks at LAST so a stalled enable can never wrap and re-arm.
  always_comb begin
    count_d   = count_q;
    expired_d = expired_q;
    if (clr) begin
      count_d   = '0;
      expired_d = 1'b0;
    end else if (en && (count_q != LAST)) begin
      count_d   = count_q + 1'b1;
      expired_d = (count_d == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule
`default_nettype wire

// File: rtl/frame_write_scheduler.sv
`default_nettype none
// =============================================================================
// frame_write_scheduler : per-frame ascending-ID arbiter for the frame-buffer write port
// Rev 1.0
// =============================================================================
module frame_write_scheduler
  import frame_sched_pkg::*;
#(
  parameter int NUM_SOURCES      = 3,
  parameter int SOURCE_SEL_ADDRW = 2,
  parameter int TIMEOUT_CYCLES   = DEFAULT_TIMEOUT_CYCLES,
  parameter int OVR_CNT_W        = 8
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        frame,
  input  logic [NUM_SOURCES-1:0]      src_req,
  input  logic [NUM_SOURCES-1:0]      src_done,
  output logic [NUM_SOURCES-1:0]      src_start,
  output logic [NUM_SOURCES-1:0]      src_abort,
  output logic                        grant_valid,
  output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
  output logic                        frame_complete,
  output logic [OVR_CNT_W-1:0]        overrun_cnt,
  output logic [NUM_SOURCES-1:0]      timeout_flags
);

  localparam int CUR_W = cur_width(NUM_SOURCES);
  localparam logic [CUR_W-1:0] END_IDX = CUR_W'(NUM_SOURCES);

  sched_state_t                state_q, state_d;
  logic [CUR_W-1:0]            cur_q, cur_d;
  logic [NUM_SOURCES-1:0]      src_start_q, src_start_d;
  logic [NUM_SOURCES-1:0]      src_abort_q, src_abort_d;
  logic                        grant_valid_q, grant_valid_d;
  logic [SOURCE_SEL_ADDRW-1:0] sel_q, sel_d;
  logic                        frame_complete_q, frame_complete_d;
  logic [OVR_CNT_W-1:0]        overrun_cnt_q, overrun_cnt_d;
  logic [NUM_SOURCES-1:0]      timeout_flags_q, timeout_flags_d;

  logic [NUM_SOURCES-1:0]      cur_oh;
  logic                        req_cur;
  logic                        done_cur;
  logic                        wd_expired;
  logic [OVR_CNT_W-1:0]        ovr_inc;

  sched_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .resetN (resetN),
    .clr    (state_q != DRAW),
    .en     (state_q == DRAW),
    .expired(wd_expired)
  );

  // cur == NUM_SOURCES decodes to all zeros, so req/done lookups are safe there.
  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      cur_oh[i] = (cur_q == CUR_W'(i));
    end
  end

  assign req_cur  = |(src_req & cur_oh);
  assign done_cur = |(src_done & cur_oh);
  assign ovr_inc  = (&overrun_cnt_q) ? overrun_cnt_q : overrun_cnt_q + 1'b1;

  always_comb begin
    state_d          = state_q;
    cur_d            = cur_q;
    src_start_d      = '0;
    src_abort_d      = '0;
    grant_valid_d    = grant_valid_q;
    sel_d            = sel_q;
    frame_complete_d = frame_complete_q;
    overrun_cnt_d    = overrun_cnt_q;
    timeout_flags_d  = timeout_flags_q;
    case (state_q)
      IDLE: begin
        if (frame) begin
          cur_d   = '0;
          state_d = SEEK;
        end
      end
      SEEK: begin
        if (frame) begin
          overrun_cnt_d = ovr_inc;
          cur_d         = '0;
        end else if (cur_q == END_IDX) begin
          state_d          = DONE;
          frame_complete_d = 1'b1;
        end else if (req_cur) begin
          state_d       = DRAW;
          src_start_d   = cur_oh;
          grant_valid_d = 1'b1;
          sel_d         = SOURCE_SEL_ADDRW'(cur_q);
        end else begin
          cur_d = cur_q + 1'b1;
        end
      end
      DRAW: begin
        // A new frame outranks both completion and timeout of the current grant.
        if (frame) begin
          overrun_cnt_d = ovr_inc;
          src_abort_d   = cur_oh;
          grant_valid_d = 1'b0;
          cur_d         = '0;
          state_d       = SEEK;
        end else if (done_cur) begin
          grant_valid_d = 1'b0;
          cur_d         = cur_q + 1'b1;
          state_d       = SEEK;
        end else if (wd_expired) begin
          src_abort_d     = cur_oh;
          timeout_flags_d = timeout_flags_q | cur_oh;
          grant_valid_d   = 1'b0;
          cur_d           = cur_q + 1'b1;
          state_d         = SEEK;
        end
      end
      DONE: begin
        if (frame) begin
          frame_complete_d = 1'b0;
          cur_d            = '0;
          state_d          = SEEK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q          <= IDLE;
      cur_q            <= '0;
      src_start_q      <= '0;
      src_abort_q      <= '0;
      grant_valid_q    <= 1'b0;
      sel_q            <= '0;
      frame_complete_q <= 1'b0;
      overrun_cnt_q    <= '0;
      timeout_flags_q  <= '0;
    end else begin
      state_q          <= state_d;
      cur_q            <= cur_d;
      src_start_q      <= src_start_d;
      src_abort_q      <= src_abort_d;
      grant_valid_q    <= grant_valid_d;
      sel_q            <= sel_d;
      frame_complete_q <= frame_complete_d;
      overrun_cnt_q    <= overrun_cnt_d;
      timeout_flags_q  <= timeout_flags_d;
    end
  end

  assign src_start        = src_start_q;
  assign src_abort        = src_abort_q;
  assign grant_valid      = grant_valid_q;
  assign write_source_sel = sel_q;
  assign frame_complete   = frame_complete_q;
  assign overrun_cnt      = overrun_cnt_q;
  assign timeout_flags    = timeout_flags_q;

endmodule
`default_nettype wire
